// File: rtl/cache_bus_arb_if.sv
// Signal bundle between the I$/D$ line-fill requesters, the bus interface and the arbiter.
// Modport master belongs to the arbiter; slave is the requester/bus side.
interface cache_bus_arb_if #(
   parameter int PA_BITS = 32,
   parameter int LOGBWPL = 2
);
   logic               IReq;
   logic [PA_BITS-1:0] IAdr;
   logic [1:0]         DBusRW;
   logic [PA_BITS-1:0] DAdr;
   logic               IAck;
   logic               DAck;
   logic [LOGBWPL-1:0] BeatCount;
   logic               SelBusBeat;
   logic [1:0]         BusRW;
   logic [PA_BITS-1:0] BusAdr;
   logic               BusReady;
   logic [1:0]         Grant;

   modport master (
      input  IReq, IAdr, DBusRW, DAdr, BusReady,
      output IAck, DAck, BeatCount, SelBusBeat, BusRW, BusAdr, Grant
   );

   modport slave (
      output IReq, IAdr, DBusRW, DAdr, BusReady,
      input  IAck, DAck, BeatCount, SelBusBeat, BusRW, BusAdr, Grant
   );
endinterface

// File: rtl/cache_bus_arb.sv
// I$/D$ line-burst bus arbiter: IDLE -> BURST -> ACKGAP, D$ writeback chained into fetch.
// Optional CACHEBUSARB_ROUNDROBIN_EN: ties go to the requester not granted most recently.
module cache_bus_arb #(
   parameter int PA_BITS = 32,
   parameter int LOGBWPL = 2
) (
   input logic             clk,
   input logic             reset,
   cache_bus_arb_if.master bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BURST  = 2'd1,
      ACKGAP = 2'd2
   } state_t;

   localparam logic [LOGBWPL-1:0] LAST_BEAT = {LOGBWPL{1'b1}};
   localparam logic [LOGBWPL-1:0] ONE_BEAT  = LOGBWPL'(1);

   state_t             stateR;
   logic [LOGBWPL-1:0] beatCountR;
   logic [1:0]         grantR;
   logic [1:0]         busRwR;
   logic [PA_BITS-1:0] busAdrR;
   logic               selBusBeatR;
   logic               fetchPendR;
   logic               beatSeenR;
   logic               rstDoneR;
`ifdef CACHEBUSARB_ROUNDROBIN_EN
   logic               lastOwnerDR;
`endif

   logic dReqS;
   logic ownerReqS;
   logic finalBeatS;
   logic pickDS;

   // Request decode, owner tracking and arbitration choice.
   always_comb begin
      dReqS      = bus.DBusRW[1] | bus.DBusRW[0];
      ownerReqS  = grantR[1] ? dReqS : bus.IReq;
      finalBeatS = (stateR == BURST) && bus.BusReady && (beatCountR == LAST_BEAT);
`ifdef CACHEBUSARB_ROUNDROBIN_EN
      if (dReqS && bus.IReq) begin
         pickDS = ~lastOwnerDR;
      end else begin
         pickDS = dReqS;
      end
`else
      pickDS = dReqS;
`endif
   end

   // Ack must fire in the same cycle the last beat is accepted, so it is decoded from BusReady.
   assign bus.IAck       = reset & finalBeatS & ~fetchPendR & grantR[0];
   assign bus.DAck       = reset & finalBeatS & ~fetchPendR & grantR[1];
   assign bus.BeatCount  = beatCountR;
   assign bus.SelBusBeat = selBusBeatR;
   assign bus.BusRW      = busRwR;
   assign bus.BusAdr     = busAdrR;
   assign bus.Grant      = grantR;

   // Arbiter state machine and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stateR      <= IDLE;
         beatCountR  <= {LOGBWPL{1'b0}};
         grantR      <= 2'b00;
         busRwR      <= 2'b00;
         busAdrR     <= {PA_BITS{1'b0}};
         selBusBeatR <= 1'b0;
         fetchPendR  <= 1'b0;
         beatSeenR   <= 1'b0;
         rstDoneR    <= 1'b0;
`ifdef CACHEBUSARB_ROUNDROBIN_EN
         lastOwnerDR <= 1'b1;
`endif
      end else begin
         rstDoneR <= 1'b1;
         case (stateR)
            IDLE: begin
               // rstDoneR holds off the first grant until the second edge out of reset.
               if (rstDoneR && (dReqS || bus.IReq)) begin
                  stateR     <= BURST;
                  beatCountR <= {LOGBWPL{1'b0}};
                  beatSeenR  <= 1'b0;
`ifdef CACHEBUSARB_ROUNDROBIN_EN
                  lastOwnerDR <= pickDS;
`endif
                  if (pickDS) begin
                     grantR  <= 2'b10;
                     busAdrR <= bus.DAdr;
                     if (bus.DBusRW[0]) begin
                        busRwR      <= 2'b01;
                        selBusBeatR <= 1'b1;
                        fetchPendR  <= bus.DBusRW[1];
                     end else begin
                        busRwR      <= 2'b10;
                        selBusBeatR <= 1'b0;
                        fetchPendR  <= 1'b0;
                     end
                  end else begin
                     grantR      <= 2'b01;
                     busAdrR     <= bus.IAdr;
                     busRwR      <= 2'b10;
                     selBusBeatR <= 1'b0;
                     fetchPendR  <= 1'b0;
                  end
               end else begin
                  stateR <= IDLE;
               end
            end
            BURST: begin
               if (bus.BusReady) begin
                  beatSeenR  <= 1'b1;
                  beatCountR <= beatCountR + ONE_BEAT;
                  if (beatCountR == LAST_BEAT) begin
                     if (fetchPendR) begin
                        // Writeback done: roll straight into the fetch without re-arbitrating.
                        fetchPendR  <= 1'b0;
                        busRwR      <= 2'b10;
                        selBusBeatR <= 1'b0;
                     end else begin
                        stateR      <= ACKGAP;
                        grantR      <= 2'b00;
                        busRwR      <= 2'b00;
                        selBusBeatR <= 1'b0;
                     end
                  end else begin
                     stateR <= BURST;
                  end
               end else if (!beatSeenR && !ownerReqS) begin
                  stateR      <= IDLE;
                  grantR      <= 2'b00;
                  busRwR      <= 2'b00;
                  selBusBeatR <= 1'b0;
                  fetchPendR  <= 1'b0;
               end else begin
                  stateR <= BURST;
               end
            end
            ACKGAP: begin
               stateR <= IDLE;
            end
            default: begin
               stateR      <= IDLE;
               beatCountR  <= {LOGBWPL{1'b0}};
               grantR      <= 2'b00;
               busRwR      <= 2'b00;
               selBusBeatR <= 1'b0;
               fetchPendR  <= 1'b0;
               beatSeenR   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cache_bus_arb.sv
// Directed bench for cache_bus_arb: single fetch, tie, writeback+fetch, stalled beats,
// early request drop, mid-burst reset and the post-reset tie.
module tb_cache_bus_arb;
   logic clk = 1'b0;
   logic reset;
   int   checks;
   int   errors;

   always #5 clk = ~clk;

   cache_bus_arb_if #(.PA_BITS(32), .LOGBWPL(2)) bif ();

   cache_bus_arb #(.PA_BITS(32), .LOGBWPL(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Four beats with BusReady held high; entered just after the edge that starts the burst.
   task automatic burst4(input string tag, input logic [1:0] g, input logic [1:0] rw,
                         input logic [31:0] adr, input logic sel, input logic ackLast);
      for (int b = 0; b < 4; b++) begin
         #1;
         chk({tag, "_grant"}, 64'(bif.Grant), 64'(g));
         chk({tag, "_busrw"}, 64'(bif.BusRW), 64'(rw));
         chk({tag, "_busadr"}, 64'(bif.BusAdr), 64'(adr));
         chk({tag, "_sel"}, 64'(bif.SelBusBeat), 64'(sel));
         chk({tag, "_beat"}, 64'(bif.BeatCount), 64'(b));
         chk({tag, "_iack"}, 64'(bif.IAck), 64'(ackLast && (g == 2'b01) && (b == 3)));
         chk({tag, "_dack"}, 64'(bif.DAck), 64'(ackLast && (g == 2'b10) && (b == 3)));
         if (b < 3) cyc();
      end
   endtask

   logic [1:0] tie2Grant;

   initial begin
      checks = 0;
      errors = 0;
`ifdef CACHEBUSARB_ROUNDROBIN_EN
      tie2Grant = 2'b01;
`else
      tie2Grant = 2'b10;
`endif
      reset = 1'b0;
      bif.IReq = 1'b0;
      bif.IAdr = 32'h0;
      bif.DBusRW = 2'b00;
      bif.DAdr = 32'h0;
      bif.BusReady = 1'b0;

      // Reset state
      cyc(); cyc(); #1;
      chk("rst_grant", 64'(bif.Grant), 64'(2'b00));
      chk("rst_busrw", 64'(bif.BusRW), 64'(2'b00));
      chk("rst_busadr", 64'(bif.BusAdr), 64'(32'h0));
      chk("rst_beat", 64'(bif.BeatCount), 64'(2'd0));
      chk("rst_sel", 64'(bif.SelBusBeat), 64'(1'b0));
      chk("rst_acks", 64'({bif.IAck, bif.DAck}), 64'(2'b00));

      // Single I$ fetch; no grant on the first edge after reset release
      reset = 1'b1;
      bif.IReq = 1'b1;
      bif.IAdr = 32'h8000_1040;
      bif.BusReady = 1'b1;
      cyc(); #1;
      chk("first_edge_grant", 64'(bif.Grant), 64'(2'b00));
      cyc();
      burst4("ifetch", 2'b01, 2'b10, 32'h8000_1040, 1'b0, 1'b1);
      bif.IReq = 1'b0;
      cyc(); #1;
      chk("ifetch_gap_grant", 64'(bif.Grant), 64'(2'b00));
      chk("ifetch_gap_busrw", 64'(bif.BusRW), 64'(2'b00));
      chk("ifetch_gap_beat", 64'(bif.BeatCount), 64'(2'd0));
      chk("ifetch_gap_iack", 64'(bif.IAck), 64'(1'b0));
      cyc(); #1;
      chk("ifetch_idle_grant", 64'(bif.Grant), 64'(2'b00));

      // Simultaneous I$ and D$ fetch: D$ first, I$ only after ACKGAP
      bif.IReq = 1'b1;
      bif.DBusRW = 2'b10;
      bif.DAdr = 32'h8000_2000;
      cyc();
      burst4("tie_d", 2'b10, 2'b10, 32'h8000_2000, 1'b0, 1'b1);
      bif.DBusRW = 2'b00;
      cyc(); #1;
      chk("tie_gap_grant", 64'(bif.Grant), 64'(2'b00));
      cyc(); #1;
      chk("tie_idle_grant", 64'(bif.Grant), 64'(2'b00));
      cyc();
      burst4("tie_i", 2'b01, 2'b10, 32'h8000_1040, 1'b0, 1'b1);
      bif.IReq = 1'b0;
      cyc(); cyc();

      // Writeback chained into fetch, single DAck after the eighth beat
      bif.DBusRW = 2'b11;
      bif.DAdr = 32'h8000_2000;
      cyc();
      burst4("wb", 2'b10, 2'b01, 32'h8000_2000, 1'b1, 1'b0);
      cyc();
      burst4("wbfetch", 2'b10, 2'b10, 32'h8000_2000, 1'b0, 1'b1);
      bif.DBusRW = 2'b00;
      cyc(); #1;
      chk("wb_gap_grant", 64'(bif.Grant), 64'(2'b00));
      chk("wb_gap_sel", 64'(bif.SelBusBeat), 64'(1'b0));
      cyc();

      // BusReady toggling; address held even when IAdr changes mid-burst
      bif.IReq = 1'b1;
      bif.IAdr = 32'h8000_3000;
      bif.BusReady = 1'b0;
      cyc();
      for (int c = 1; c <= 7; c++) begin
         bif.BusReady = (c % 2 == 1);
         if (c == 2) bif.IAdr = 32'h0BAD_0000;
         #1;
         chk("tog_beat", 64'(bif.BeatCount), 64'(c / 2));
         chk("tog_iack", 64'(bif.IAck), 64'(c == 7));
         chk("tog_busadr", 64'(bif.BusAdr), 64'(32'h8000_3000));
         if (c == 7) bif.IReq = 1'b0;
         cyc();
      end
      #1;
      chk("tog_gap_grant", 64'(bif.Grant), 64'(2'b00));
      cyc();

      // D$ request dropped before the first accepted beat: abort, no DAck
      bif.DBusRW = 2'b10;
      bif.DAdr = 32'h8000_4000;
      bif.BusReady = 1'b0;
      cyc(); #1;
      chk("drop0_grant", 64'(bif.Grant), 64'(2'b10));
      bif.DBusRW = 2'b00;
      #1;
      chk("drop0_dack_a", 64'(bif.DAck), 64'(1'b0));
      cyc(); #1;
      chk("drop0_abort_grant", 64'(bif.Grant), 64'(2'b00));
      chk("drop0_abort_busrw", 64'(bif.BusRW), 64'(2'b00));
      cyc(); #1;
      chk("drop0_idle_grant", 64'(bif.Grant), 64'(2'b00));
      chk("drop0_dack_b", 64'(bif.DAck), 64'(1'b0));

      // D$ request dropped after the first beat: burst completes with DAck
      bif.DBusRW = 2'b10;
      bif.BusReady = 1'b1;
      cyc(); #1;
      chk("drop1_beat0", 64'(bif.BeatCount), 64'(2'd0));
      cyc(); #1;
      bif.DBusRW = 2'b00;
      chk("drop1_beat1", 64'(bif.BeatCount), 64'(2'd1));
      chk("drop1_grant1", 64'(bif.Grant), 64'(2'b10));
      cyc(); #1;
      chk("drop1_beat2", 64'(bif.BeatCount), 64'(2'd2));
      chk("drop1_dack2", 64'(bif.DAck), 64'(1'b0));
      cyc(); #1;
      chk("drop1_beat3", 64'(bif.BeatCount), 64'(2'd3));
      chk("drop1_dack3", 64'(bif.DAck), 64'(1'b1));
      cyc(); #1;
      chk("drop1_gap_grant", 64'(bif.Grant), 64'(2'b00));
      chk("drop1_gap_dack", 64'(bif.DAck), 64'(1'b0));
      cyc();

      // Reset on beat 2 abandons the burst with no IAck
      bif.IReq = 1'b1;
      bif.IAdr = 32'h8000_5000;
      bif.BusReady = 1'b1;
      cyc(); cyc(); cyc(); #1;
      chk("mrst_beat2", 64'(bif.BeatCount), 64'(2'd2));
      reset = 1'b0;
      #1;
      chk("mrst_iack_pre", 64'(bif.IAck), 64'(1'b0));
      cyc(); #1;
      chk("mrst_grant", 64'(bif.Grant), 64'(2'b00));
      chk("mrst_busrw", 64'(bif.BusRW), 64'(2'b00));
      chk("mrst_busadr", 64'(bif.BusAdr), 64'(32'h0));
      chk("mrst_beat", 64'(bif.BeatCount), 64'(2'd0));
      chk("mrst_acks", 64'({bif.IAck, bif.DAck}), 64'(2'b00));
      bif.IReq = 1'b0;
      cyc();

      // Tie right after reset release (round-robin state back at its reset value)
      reset = 1'b1;
      bif.IReq = 1'b1;
      bif.DBusRW = 2'b10;
      bif.DAdr = 32'h8000_6000;
      bif.BusReady = 1'b0;
      cyc(); #1;
      chk("tie2_first_edge", 64'(bif.Grant), 64'(2'b00));
      cyc(); #1;
      chk("tie2_grant", 64'(bif.Grant), 64'(tie2Grant));
      bif.IReq = 1'b0;
      bif.DBusRW = 2'b00;
      cyc(); #1;
      chk("tie2_abort_grant", 64'(bif.Grant), 64'(2'b00));
      chk("tie2_abort_acks", 64'({bif.IAck, bif.DAck}), 64'(2'b00));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
